// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO controller.
// Pointer/count widths here track the default depth; modules re-derive them from their own parameters.
package fifo_pkg;
    localparam int FIFO_DEPTH     = 16;
    localparam int FIFO_PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int FIFO_AF_THRESH = FIFO_DEPTH - 2;
    localparam int FIFO_AE_THRESH = 2;

    typedef logic [FIFO_PTR_WIDTH:0] ptr_t;
    typedef logic [FIFO_PTR_WIDTH:0] cnt_t;
endpackage

// File: rtl/fifo_ptr.sv
// Binary pointer counter with wrap bit: increments on inc, sync clear wins over inc.
// Latency: new value visible one edge after inc; async reset to zero.
// Backpressure: none, the caller gates inc.
module fifo_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + W'(1);
    end
endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller for fifo_mem: pointers, occupancy and registered status flags.
// Latency: push written at the accepting edge, visible on r_data the next cycle; flags never lag count.
// Backpressure: push dropped while full, pop dropped while empty; optional sticky errors via SYNC_FIFO_CTRL_ERR_EN.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = FIFO_AE_THRESH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    output logic                 mem_w_en,
    output logic [PTR_WIDTH-1:0] mem_w_addr,
    output logic [PTR_WIDTH-1:0] mem_r_addr,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   count
`ifdef SYNC_FIFO_CTRL_ERR_EN
    ,
    input  logic                 err_clr,
    output logic                 overflow,
    output logic                 underflow
`endif
);
    typedef logic [PTR_WIDTH:0] lcnt_t;

    localparam lcnt_t DEPTH_C = lcnt_t'(DEPTH);
    localparam lcnt_t AF_C    = lcnt_t'(AF_THRESH);
    localparam lcnt_t AE_C    = lcnt_t'(AE_THRESH);

    logic [PTR_WIDTH:0] w_ptr;
    logic [PTR_WIDTH:0] r_ptr;
    lcnt_t              count_next;
    logic               wr_acc;
    logic               rd_acc;

    assign wr_acc     = push && !full && !flush;
    assign rd_acc     = pop && !empty && !flush;
    assign mem_w_en   = wr_acc;
    assign mem_w_addr = w_ptr[PTR_WIDTH-1:0];
    assign mem_r_addr = r_ptr[PTR_WIDTH-1:0];

    fifo_ptr #(.W(PTR_WIDTH + 1)) u_w_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_acc),
        .clr (flush),
        .ptr (w_ptr)
    );

    fifo_ptr #(.W(PTR_WIDTH + 1)) u_r_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_acc),
        .clr (flush),
        .ptr (r_ptr)
    );

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (wr_acc && !rd_acc)
            count_next = count + lcnt_t'(1);
        else if (rd_acc && !wr_acc)
            count_next = count - lcnt_t'(1);
    end

    // Flags come from count_next so they settle at the same edge as the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
        end
    end

`ifdef SYNC_FIFO_CTRL_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full && !flush)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;
            if (pop && empty && !flush)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl at DEPTH=16 with a behavioural fifo_mem beside it.
module tb_sync_fifo_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       flush = 1'b0;
    logic       mem_w_en;
    logic [3:0] mem_w_addr;
    logic [3:0] mem_r_addr;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
`ifdef SYNC_FIFO_CTRL_ERR_EN
    logic       err_clr = 1'b0;
    logic       overflow;
    logic       underflow;
`endif

    logic [7:0] w_data = 8'h00;
    logic [7:0] r_data;
    logic [7:0] mem [16];

    int         n_cmp = 0;
    int         n_err = 0;
    int         prev_cnt = 0;
    logic [7:0] dat_seq = 8'h10;
    logic       wrapped = 1'b0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    sync_fifo_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .flush        (flush),
        .mem_w_en     (mem_w_en),
        .mem_w_addr   (mem_w_addr),
        .mem_r_addr   (mem_r_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef SYNC_FIFO_CTRL_ERR_EN
        ,
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    always @(posedge clk)
        if (mem_w_en) mem[mem_w_addr] <= w_data;
    assign r_data = mem[mem_r_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int c);
        logic [3:0] diff;
        chk({tag, "_count"}, 32'(count), 32'(c));
        chk({tag, "_full"}, 32'(full), 32'(c == 16));
        chk({tag, "_empty"}, 32'(empty), 32'(c == 0));
        chk({tag, "_af"}, 32'(almost_full), 32'(c >= 14));
        chk({tag, "_ae"}, 32'(almost_empty), 32'(c <= 2));
        diff = mem_w_addr - mem_r_addr;
        chk({tag, "_inv"}, 32'(diff), 32'(c % 16));
    endtask

    // One clock of stimulus: checks write enable and head word before the edge, state after.
    task automatic op(input logic p, input logic q, input logic f,
                      input logic exp_wen, input int exp_cnt, input string tag);
        logic [7:0] d;
        logic [3:0] old_wa;
        d = dat_seq;
        dat_seq = dat_seq + 8'd1;
        push = p; pop = q; flush = f; w_data = d;
        #1;
        chk({tag, "_wen"}, 32'(mem_w_en), 32'(exp_wen));
        if (q && !f && prev_cnt > 0) begin
            if (sb.size() == 0)
                chk({tag, "_sb"}, 32'(0), 32'(1));
            else
                chk({tag, "_rdat"}, 32'(r_data), 32'(sb.pop_front()));
        end
        if (exp_wen) sb.push_back(d);
        if (f) sb.delete();
        old_wa = mem_w_addr;
        @(posedge clk);
        #1;
        if (old_wa == 4'd15 && mem_w_addr == 4'd0) wrapped = 1'b1;
        push = 1'b0; pop = 1'b0; flush = 1'b0;
        chk_state(tag, exp_cnt);
        prev_cnt = exp_cnt;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_state("rst_hold", 0);
        chk("rst_waddr", 32'(mem_w_addr), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) op(1, 0, 0, 1, i + 1, "pre");
        rst = 1'b1;
        #1;
        chk_state("mid_rst", 0);
        chk("mid_rst_waddr", 32'(mem_w_addr), 32'd0);
        chk("mid_rst_raddr", 32'(mem_r_addr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        prev_cnt = 0;

        for (int i = 0; i < 16; i++) op(1, 0, 0, 1, i + 1, "fill");
        op(1, 0, 0, 0, 16, "push_full");
`ifdef SYNC_FIFO_CTRL_ERR_EN
        chk("ovf_set", 32'(overflow), 32'd1);
        op(0, 0, 0, 0, 16, "idle_full");
        chk("ovf_hold", 32'(overflow), 32'd1);
        err_clr = 1'b1;
        op(0, 0, 0, 0, 16, "err_clr");
        err_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);
`endif
        for (int i = 0; i < 16; i++) op(0, 1, 0, 0, 15 - i, "drain");
        op(0, 1, 0, 0, 0, "pop_empty");
`ifdef SYNC_FIFO_CTRL_ERR_EN
        chk("unf_set", 32'(underflow), 32'd1);
`endif

        op(1, 1, 0, 1, 1, "pp_empty");
        op(1, 0, 0, 1, 2, "pre_wrap");
        op(1, 0, 0, 1, 3, "pre_wrap");
        dat_seq = 8'hA0;
        wrapped = 1'b0;
        for (int i = 0; i < 20; i++) op(1, 1, 0, 1, 3, "wrap");
        chk("wrap_addr", 32'(wrapped), 32'd1);
        for (int i = 0; i < 3; i++) op(0, 1, 0, 0, 2 - i, "post_wrap");

        for (int i = 0; i < 7; i++) op(1, 0, 0, 1, i + 1, "to7");
        op(1, 1, 0, 1, 7, "pp_7");
        for (int i = 0; i < 9; i++) op(1, 0, 0, 1, i + 8, "to16");
        op(1, 1, 0, 0, 15, "pp_full");
        for (int i = 0; i < 6; i++) op(0, 1, 0, 0, 14 - i, "to9");
        op(1, 0, 1, 0, 0, "flush");
        op(0, 0, 0, 0, 0, "post_flush");
        op(1, 0, 0, 1, 1, "after_flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
